// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: groups the instruction-memory request/response channel, the
// redirect input and the decode handshake of ifetch_queue.
//   master : the fetch stage (drives imem_req_*, id_*; receives imem_rsp_*,
//            redirect*, id_ready)
//   slave  : the environment (instruction memory + decode stage)
`timescale 1ns/1ps
interface ifetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect,
           redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect,
           redirect_pc, id_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch stage with a DEPTH-entry prefetch queue.
// Issues sequential word-aligned fetches, tags in-flight requests with their
// PC, buffers returned words and hands {instr, pc} to decode one per
// handshake. A redirect flushes the queue and discards in-flight responses.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : ifetch_queue_if.master (imem_req_*, imem_rsp_*, redirect*, id_*)
// Parameters: DEPTH (power of two, 2..16), RESET_PC.
// Build option: define IFQ_BYPASS_EN to forward a response straight to decode
// when the queue is empty (otherwise the response-to-decode path is registered).
`timescale 1ns/1ps
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           reset,
  ifetch_queue_if.master bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [SW-1:0] LIMIT = SW'(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        run_q;
  ptr_t        rptr_q, rptr_d, wptr_q, wptr_d;
  ptr_t        trptr_q, trptr_d, twptr_q, twptr_d;
  cnt_t        count_q, count_d, out_q, out_d, drop_q, drop_d;

  logic [31:0] instr_q [DEPTH];
  logic [31:0] ipc_q   [DEPTH];
  logic [31:0] tag_q   [DEPTH];

  logic          empty, full, accept, rsp_drop, rsp_take, push, pop;
  logic          byp_consume;
  logic [SW-1:0] inflight;
  logic [31:0]   rsp_pc;

  logic unused_pc_bits;
  assign unused_pc_bits = ^bus.redirect_pc[1:0];

  assign empty    = (count_q == '0);
  assign full     = (count_q == cnt_t'(DEPTH));
  assign inflight = {1'b0, count_q} + {1'b0, out_q};
  assign rsp_pc   = tag_q[trptr_q];

  assign bus.imem_req_valid = run_q & ~bus.redirect & (inflight < LIMIT);
  assign bus.imem_req_addr  = fetch_pc_q;
  assign accept = bus.imem_req_valid & bus.imem_req_ready;

  assign rsp_drop = bus.imem_rsp_valid & (drop_q != '0);
  // A response arriving while the queue is full violates the issue rule; ignore it.
  assign rsp_take = bus.imem_rsp_valid & (drop_q == '0) & ~full;

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass      = rsp_take & empty & ~bus.redirect;
  assign byp_consume = bypass & bus.id_ready;
  assign bus.id_valid = ~empty | bypass;
  assign bus.id_instr = ~empty ? instr_q[rptr_q] : (bypass ? bus.imem_rsp_data : NOP);
  assign bus.id_pc    = ~empty ? ipc_q[rptr_q]   : (bypass ? rsp_pc : 32'h0);
`else
  assign byp_consume  = 1'b0;
  assign bus.id_valid = ~empty;
  assign bus.id_instr = ~empty ? instr_q[rptr_q] : NOP;
  assign bus.id_pc    = ~empty ? ipc_q[rptr_q]   : 32'h0;
`endif

  assign push = rsp_take & ~byp_consume & ~bus.redirect;
  assign pop  = ~empty & bus.id_ready & ~bus.redirect;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    trptr_d    = trptr_q;
    twptr_d    = twptr_q;
    count_d    = count_q;
    out_d      = out_q;
    drop_d     = drop_q;
    if (bus.redirect) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      rptr_d     = '0;
      wptr_d     = '0;
      trptr_d    = '0;
      twptr_d    = '0;
      count_d    = '0;
      out_d      = '0;
      // Every in-flight word becomes stale; a word arriving now is discarded
      // on the spot, so it leaves the combined drop+outstanding total.
      drop_d = drop_q + out_q;
      if (bus.imem_rsp_valid && (drop_d != '0)) drop_d = drop_d - cnt_t'(1);
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        twptr_d    = twptr_q + ptr_t'(1);
      end
      if (rsp_take) trptr_d = trptr_q + ptr_t'(1);
      if (push)     wptr_d  = wptr_q + ptr_t'(1);
      if (pop)      rptr_d  = rptr_q + ptr_t'(1);
      count_d = count_q + cnt_t'(push) - cnt_t'(pop);
      out_d   = out_q + cnt_t'(accept) - cnt_t'(rsp_take);
      drop_d  = drop_q - cnt_t'(rsp_drop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      run_q      <= 1'b0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      trptr_q    <= '0;
      twptr_q    <= '0;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      run_q      <= 1'b1;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      trptr_q    <= trptr_d;
      twptr_q    <= twptr_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  // Storage arrays carry no reset; contents are only visible through count_q.
  always_ff @(posedge clk) begin
    if (accept) tag_q[twptr_q] <= fetch_pc_q;
    if (push) begin
      instr_q[wptr_q] <= bus.imem_rsp_data;
      ipc_q[wptr_q]   <= rsp_pc;
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
`timescale 1ns/1ps
module tb_ifetch_queue;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifetch_queue_if bus();

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] addr; int unsigned due; } pend_t;
  pend_t       pend[$];
  logic [31:0] exp_pc[$];
  int unsigned cyc = 0;
  int unsigned accept_cnt = 0;
  int unsigned lat = 1;
  logic        man_en = 1'b0, man_valid = 1'b0;
  logic [31:0] man_data = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Request snoop: every accepted request goes to the memory model and the
  // decode scoreboard.
  always @(posedge clk) begin
    if (!reset) pend.delete();
    else if (bus.imem_req_valid && bus.imem_req_ready) begin
      pend.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
      exp_pc.push_back(bus.imem_req_addr);
      accept_cnt <= accept_cnt + 1;
    end
    cyc <= cyc + 1;
  end

  // Memory model: in-order responses, fixed latency, or manual override.
  always @(negedge clk) begin
    if (man_en) begin
      bus.imem_rsp_valid = man_valid;
      bus.imem_rsp_data  = man_data;
    end else if (pend.size() > 0 && cyc >= pend[0].due) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic apply_reset();
    step();
    reset = 1'b0;
    man_en = 1'b0; man_valid = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.id_ready = 1'b0; bus.imem_req_ready = 1'b1;
    repeat (2) step();
    exp_pc.delete();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    step();
    reset = 1'b0;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", bus.imem_req_valid); end
    checks++; if (bus.imem_req_addr !== 32'h100) begin failures++; $display("FAIL reset_req_addr got=%h exp=00000100", bus.imem_req_addr); end
    checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%b exp=0", bus.id_valid); end
    checks++; if (bus.id_instr !== 32'h13) begin failures++; $display("FAIL reset_id_instr got=%h exp=00000013", bus.id_instr); end
    checks++; if (bus.id_pc !== 32'h0) begin failures++; $display("FAIL reset_id_pc got=%h exp=0", bus.id_pc); end
    repeat (2) step();
    exp_pc.delete();
    reset = 1'b1;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL release_req_valid got=%b exp=0", bus.imem_req_valid); end
    step(); #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin
      failures++; $display("FAIL first_req got=%b/%h exp=1/00000100", bus.imem_req_valid, bus.imem_req_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_req = 32'h100;
    logic [31:0] e;
    bit started = 0;
    int pops = 0;
    apply_reset();
    lat = 1; bus.id_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step(); #1;
      if (bus.imem_req_valid) begin
        checks++; if (bus.imem_req_addr !== exp_req) begin failures++; $display("FAIL stream_req_addr got=%h exp=%h", bus.imem_req_addr, exp_req); end
        exp_req = exp_req + 32'd4;
      end
      if (bus.id_valid) begin
        started = 1; pops++;
        checks++;
        if (exp_pc.size() == 0) begin failures++; $display("FAIL stream_sb got_pc=%h exp=none", bus.id_pc); end
        else begin
          e = exp_pc.pop_front();
          if (bus.id_pc !== e || bus.id_instr !== mem_word(e)) begin
            failures++; $display("FAIL stream_pop got=%h/%h exp=%h/%h", bus.id_pc, bus.id_instr, e, mem_word(e)); end
        end
      end else if (started) begin
        checks++; failures++; $display("FAIL stream_bubble got id_valid=0 exp=1 at i=%0d", i);
      end
    end
    checks++; if (pops < 20) begin failures++; $display("FAIL stream_pops got=%0d exp>=20", pops); end
  endtask

  task automatic test_backpressure();
    int unsigned base;
    logic [31:0] e;
    apply_reset();
    lat = 1; base = accept_cnt;
    repeat (10) step();
    #1;
    checks++; if (accept_cnt - base != 4) begin failures++; $display("FAIL bp_accepts got=%0d exp=4", accept_cnt - base); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid got=%b exp=0", bus.imem_req_valid); end
    step();
    bus.id_ready = 1'b1;
    #1;
    checks++;
    if (exp_pc.size() == 0) begin failures++; $display("FAIL bp_sb got_pc=%h exp=none", bus.id_pc); end
    else begin
      e = exp_pc.pop_front();
      if (bus.id_valid !== 1'b1 || bus.id_pc !== e) begin failures++; $display("FAIL bp_pop got=%b/%h exp=1/%h", bus.id_valid, bus.id_pc, e); end
    end
    step();
    bus.id_ready = 1'b0;
    repeat (6) step();
    #1;
    checks++; if (accept_cnt - base != 5) begin failures++; $display("FAIL bp_one_more got=%0d exp=5", accept_cnt - base); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid2 got=%b exp=0", bus.imem_req_valid); end
  endtask

  task automatic test_redirect();
    int unsigned base;
    bit hit = 0, first = 1;
    logic [31:0] e;
    apply_reset();
    lat = 3; base = accept_cnt;
    for (int i = 0; i < 10 && !hit; i++) begin
      step(); #1;
      if (accept_cnt - base == 2) hit = 1;
    end
    checks++; if (!hit) begin failures++; $display("FAIL redir_setup got=%0d accepts exp=2", accept_cnt - base); end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_2002;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL redir_no_req got=%b exp=0", bus.imem_req_valid); end
    exp_pc.delete();
    step();
    bus.redirect = 1'b0; bus.id_ready = 1'b1;
    #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h2000) begin
      failures++; $display("FAIL redir_target got=%b/%h exp=1/00002000", bus.imem_req_valid, bus.imem_req_addr); end
    for (int i = 0; i < 15; i++) begin
      step(); #1;
      if (bus.id_valid) begin
        checks++;
        if (exp_pc.size() == 0) begin failures++; $display("FAIL redir_stale got_pc=%h exp=none", bus.id_pc); end
        else begin
          e = exp_pc.pop_front();
          if (first && e !== 32'h2000) begin failures++; $display("FAIL redir_first got=%h exp=00002000", e); end
          else if (bus.id_pc !== e || bus.id_instr !== mem_word(e)) begin
            failures++; $display("FAIL redir_pop got=%h/%h exp=%h/%h", bus.id_pc, bus.id_instr, e, mem_word(e)); end
          first = 0;
        end
      end
    end
    checks++; if (first) begin failures++; $display("FAIL redir_nothing got=0 pops exp>0"); end
  endtask

  task automatic test_redirect_collision();
    logic [31:0] e;
    bit first = 1;
    apply_reset();
    lat = 1; bus.id_ready = 1'b1;
    repeat (6) begin
      step(); #1;
      if (bus.id_valid && exp_pc.size() > 0) void'(exp_pc.pop_front());
    end
    step();
    bus.id_ready = 1'b0;
    step();
    bus.id_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_3000;
    #1;
    checks++; if (bus.id_valid !== 1'b1 || bus.imem_rsp_valid !== 1'b1) begin
      failures++; $display("FAIL coll_setup got id_valid=%b rsp=%b exp=1/1", bus.id_valid, bus.imem_rsp_valid); end
    checks++;
    if (exp_pc.size() == 0) begin failures++; $display("FAIL coll_sb got_pc=%h exp=none", bus.id_pc); end
    else begin
      e = exp_pc.pop_front();
      if (bus.id_pc !== e) begin failures++; $display("FAIL coll_head got=%h exp=%h", bus.id_pc, e); end
    end
    exp_pc.delete();
    step();
    bus.redirect = 1'b0;
    #1;
    checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL coll_empty got=%b exp=0", bus.id_valid); end
    checks++; if (bus.imem_req_addr !== 32'h3000) begin failures++; $display("FAIL coll_target got=%h exp=00003000", bus.imem_req_addr); end
    for (int i = 0; i < 12; i++) begin
      step(); #1;
      if (bus.id_valid) begin
        checks++;
        if (exp_pc.size() == 0) begin failures++; $display("FAIL coll_stale got_pc=%h exp=none", bus.id_pc); end
        else begin
          e = exp_pc.pop_front();
          if ((first && bus.id_pc !== 32'h3000) || bus.id_pc !== e || bus.id_instr !== mem_word(e)) begin
            failures++; $display("FAIL coll_pop got=%h/%h exp=%h/%h", bus.id_pc, bus.id_instr, e, mem_word(e)); end
          first = 0;
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_req = 32'hFFFF_FFF8;
    logic [31:0] e;
    int reqs = 0;
    apply_reset();
    lat = 1; bus.id_ready = 1'b1;
    step();
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
    #1;
    exp_pc.delete();
    step();
    bus.redirect = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.imem_req_valid) begin
        reqs++;
        checks++; if (bus.imem_req_addr !== exp_req) begin failures++; $display("FAIL wrap_addr got=%h exp=%h", bus.imem_req_addr, exp_req); end
        exp_req = exp_req + 32'd4;
      end
      if (bus.id_valid) begin
        checks++;
        if (exp_pc.size() == 0) begin failures++; $display("FAIL wrap_sb got_pc=%h exp=none", bus.id_pc); end
        else begin
          e = exp_pc.pop_front();
          if (bus.id_pc !== e || bus.id_instr !== mem_word(e)) begin
            failures++; $display("FAIL wrap_pop got=%h/%h exp=%h/%h", bus.id_pc, bus.id_instr, e, mem_word(e)); end
        end
      end
      step();
    end
    checks++; if (reqs < 3) begin failures++; $display("FAIL wrap_reqs got=%0d exp>=3", reqs); end
  endtask

  task automatic test_bypass();
    apply_reset();
    man_en = 1'b1; man_valid = 1'b0;
    bus.id_ready = 1'b1; bus.imem_req_ready = 1'b1;
    step(); #1;
    checks++; if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin
      failures++; $display("FAIL byp_req got=%b/%h exp=1/00000100", bus.imem_req_valid, bus.imem_req_addr); end
    step();
    bus.imem_req_ready = 1'b0;
    man_valid = 1'b1; man_data = 32'h0050_0093;
    step();
    man_valid = 1'b0;
    #1;
`ifdef IFQ_BYPASS_EN
    checks++; if (bus.id_valid !== 1'b1 || bus.id_instr !== 32'h0050_0093 || bus.id_pc !== 32'h100) begin
      failures++; $display("FAIL byp_same_cycle got=%b/%h/%h exp=1/00500093/00000100", bus.id_valid, bus.id_instr, bus.id_pc); end
    step(); #1;
    checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL byp_count got=%b exp=0", bus.id_valid); end
`else
    checks++; if (bus.id_valid !== 1'b0 || bus.id_instr !== 32'h13) begin
      failures++; $display("FAIL nobyp_cycle_n got=%b/%h exp=0/00000013", bus.id_valid, bus.id_instr); end
    step(); #1;
    checks++; if (bus.id_valid !== 1'b1 || bus.id_instr !== 32'h0050_0093 || bus.id_pc !== 32'h100) begin
      failures++; $display("FAIL nobyp_cycle_n1 got=%b/%h/%h exp=1/00500093/00000100", bus.id_valid, bus.id_instr, bus.id_pc); end
    step(); #1;
    checks++; if (bus.id_valid !== 1'b0) begin failures++; $display("FAIL nobyp_drain got=%b exp=0", bus.id_valid); end
`endif
    man_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.id_ready = 1'b0; bus.imem_req_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_collision();
    test_wrap();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
